// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one UART transmit channel among
// NUM_REQ valid/ready byte-stream requesters. A grant is held for a whole
// message (ended by req_last_i) or until MAX_LEN bytes have been sent.
// Optional build macro: UART_TX_ARB_HDR_EN adds a one-byte header
// {1'b1, grant id} in front of every granted segment.
module uart_tx_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 256,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [ID_W-1:0]               grant_id_o,
  output logic                          busy_o
);

`ifdef UART_TX_ARB_HDR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PASS = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd2} state_t;
`endif

  state_t            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   grant_q;
  logic [LEN_W-1:0]  len_cnt_q;
  logic              busy_q;

  logic [ID_W-1:0]   ptr_d;
  logic [LEN_W-1:0]  len_cnt_d;
  logic [ID_W:0]     cand;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;

  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  xfer;
  logic                  msg_end;

  // Granted requester's channel, selected by the registered grant index.
  assign g_valid = req_valid_i[grant_q];
  assign g_last  = req_last_i[grant_q];
  assign g_data  = req_data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

  // A byte moves only while passing through; the header cycle never counts.
  assign xfer    = (state_q == PASS) && g_valid && tx_ready_i;
  assign msg_end = g_last || (len_cnt_q == LEN_W'(MAX_LEN - 1));

  assign ptr_d     = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign len_cnt_d = len_cnt_q + 1'b1;

  assign grant_id_o = grant_q;
  assign busy_o     = busy_q;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  // Loop runs from the farthest offset down so the nearest one wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (req_valid_i[cand[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[ID_W-1:0];
      end
    end
  end

`ifdef UART_TX_ARB_HDR_EN
  localparam int HW = DATA_WIDTH - 1;
  logic [HW-1:0] hdr_id;
  assign hdr_id = HW'(grant_q);
`endif

  // Transmit side and requester accepts; tx_data is forced to zero when idle.
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    case (state_q)
      PASS: begin
        tx_valid_o           = g_valid;
        tx_data_o            = g_data;
        req_ready_o[grant_q] = tx_ready_i;
      end
`ifdef UART_TX_ARB_HDR_EN
      HDR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = {1'b1, hdr_id};
      end
`endif
      default: begin
      end
    endcase
  end

  // Arbitration FSM: grant in IDLE, hold through the message, rotate on release.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      len_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q   <= pick_idx;
            len_cnt_q <= '0;
            busy_q    <= 1'b1;
`ifdef UART_TX_ARB_HDR_EN
            state_q   <= HDR;
`else
            state_q   <= PASS;
`endif
          end
        end
`ifdef UART_TX_ARB_HDR_EN
        HDR: begin
          if (tx_ready_i) begin
            state_q <= PASS;
          end
        end
`endif
        PASS: begin
          if (xfer) begin
            if (msg_end) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              ptr_q   <= ptr_d;
            end else begin
              len_cnt_q <= len_cnt_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb (NUM_REQ=4, DATA_WIDTH=8, MAX_LEN=4).
// Header-specific steps are compiled in when UART_TX_ARB_HDR_EN is defined.
module tb_uart_tx_arb;

  logic        clk;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  grant_id;
  logic        busy;

  int pass_cnt;
  int fail_cnt;
  int cnt [4];

  uart_tx_arb #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .MAX_LEN    (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_valid"}, 32'(tx_valid),  32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_data"},  32'(tx_data),   32'd0);
  endtask

  task automatic chk_byte(input string tag, input int g, input logic [7:0] d);
    chk({tag, "_busy"},  32'(busy),      32'd1);
    chk({tag, "_gnt"},   32'(grant_id),  32'(g));
    chk({tag, "_valid"}, 32'(tx_valid),  32'd1);
    chk({tag, "_data"},  32'(tx_data),   32'(d));
    chk({tag, "_ready"}, 32'(req_ready), 32'(1 << g));
  endtask

  // Header cycle after each grant (header build only), with tx_ready high.
  task automatic hdr(input int g);
`ifdef UART_TX_ARB_HDR_EN
    settle();
    chk("hdr_valid", 32'(tx_valid),  32'd1);
    chk("hdr_data",  32'(tx_data),   32'(8'h80 | g));
    chk("hdr_ready", 32'(req_ready), 32'd0);
    chk("hdr_busy",  32'(busy),      32'd1);
    tick();
`else
    if (g < 0) $display("unused header index %0d", g);
`endif
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[i*8 +: 8] = d;
    req_last[i]        = l;
  endtask

  task automatic drive_t2();
    for (int i = 0; i < 4; i++) begin
      set_req(i, 1'b1, 8'((i << 4) | cnt[i]), cnt[i] == 1);
    end
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int g;
    pass_cnt = 0;
    fail_cnt = 0;

    // Reset state
    rstn = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    tick();
    tick();
    chk_idle("rst");
    chk("rst_gnt", 32'(grant_id), 32'd0);
    rstn = 1'b1;

    // Test 1: requester 0 sends 0x11,0x22,0x33 with one-cycle latency
    set_req(0, 1'b1, 8'h11, 1'b0);
    settle(); chk_idle("t1_idle");
    tick(); hdr(0);
    settle(); chk_byte("t1_b0", 0, 8'h11);
    tick(); set_req(0, 1'b1, 8'h22, 1'b0);
    settle(); chk_byte("t1_b1", 0, 8'h22);
    tick(); set_req(0, 1'b1, 8'h33, 1'b1);
    settle(); chk_byte("t1_b2", 0, 8'h33);
    tick(); set_req(0, 1'b0, 8'h00, 1'b0);
    settle(); chk_idle("t1_bubble");

    // Test 2: all four hold 2-byte messages; grants 0,1,2,3,0 with no interleave
    do_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int m = 0; m < 5; m++) begin
      g = m % 4;
      drive_t2(); settle(); chk_idle("t2_idle");
      tick(); hdr(g);
      drive_t2(); settle(); chk_byte("t2_b0", g, 8'(g << 4));
      tick(); cnt[g] = 1;
      drive_t2(); settle(); chk_byte("t2_b1", g, 8'((g << 4) | 1));
      tick(); cnt[g] = 0;
    end

    // Test 3: MAX_LEN=4 forced rotation; ptr is 1 here
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(3, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b1, 8'h10, 1'b0);
    set_req(2, 1'b1, 8'hC2, 1'b1);
    settle(); chk_idle("t3_idle0");
    tick(); hdr(1);
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, 8'(8'h10 + k), 1'b0);
      settle(); chk_byte("t3_seg1", 1, 8'(8'h10 + k));
      tick();
    end
    set_req(1, 1'b1, 8'h14, 1'b0);
    settle(); chk_idle("t3_idle1");
    tick(); hdr(2);
    settle(); chk_byte("t3_r2", 2, 8'hC2);
    tick(); set_req(2, 1'b0, 8'h00, 1'b0);
    settle(); chk_idle("t3_idle2");
    tick(); hdr(1);
    for (int k = 4; k < 8; k++) begin
      set_req(1, 1'b1, 8'(8'h10 + k), 1'b0);
      settle(); chk_byte("t3_seg2", 1, 8'(8'h10 + k));
      tick();
    end
    set_req(1, 1'b1, 8'h18, 1'b0);
    settle(); chk_idle("t3_idle3");
    tick(); hdr(1);
    for (int k = 8; k < 10; k++) begin
      set_req(1, 1'b1, 8'(8'h10 + k), 1'b0);
      settle(); chk_byte("t3_seg3", 1, 8'(8'h10 + k));
      tick();
    end
    set_req(1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t3_hold_busy",  32'(busy),      32'd1);
      chk("t3_hold_gnt",   32'(grant_id),  32'd1);
      chk("t3_hold_valid", 32'(tx_valid),  32'd0);
      tick();
    end

    // Test 4: tx_ready 1,0,0,1 stalls; byte held, req_ready mirrors tx_ready
    do_reset();
    set_req(0, 1'b1, 8'hA1, 1'b0);
    settle(); chk_idle("t4_idle");
    tick(); hdr(0);
    settle(); chk_byte("t4_a1", 0, 8'hA1);
    tick(); set_req(0, 1'b1, 8'hA2, 1'b0); tx_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t4_stall_valid", 32'(tx_valid),  32'd1);
      chk("t4_stall_data",  32'(tx_data),   32'hA2);
      chk("t4_stall_ready", 32'(req_ready), 32'd0);
      tick();
    end
    tx_ready = 1'b1;
    settle(); chk_byte("t4_a2", 0, 8'hA2);
    tick(); set_req(0, 1'b1, 8'hA3, 1'b1);
    settle(); chk_byte("t4_a3", 0, 8'hA3);
    tick(); set_req(0, 1'b0, 8'h00, 1'b0);
    settle(); chk_idle("t4_end");

    // Test 5: reset mid-message from requester 3; ptr is 1 before this
    set_req(3, 1'b1, 8'hD0, 1'b0);
    tick(); hdr(3);
    settle(); chk_byte("t5_d0", 3, 8'hD0);
    tick(); set_req(3, 1'b1, 8'hD1, 1'b1);
    settle(); chk_byte("t5_d1", 3, 8'hD1);
    rstn = 1'b0;
    tick();
    chk_idle("t5_rst");
    chk("t5_rst_gnt", 32'(grant_id), 32'd0);
    rstn = 1'b1;
    set_req(0, 1'b1, 8'hE0, 1'b1);
    settle(); chk_idle("t5_idle");
    tick(); hdr(0);
    settle(); chk_byte("t5_win0", 0, 8'hE0);
    tick(); set_req(0, 1'b0, 8'h00, 1'b0);
    settle(); chk_idle("t5_bubble");
    tick(); hdr(3);
    settle(); chk_byte("t5_then3", 3, 8'hD1);
    tick(); set_req(3, 1'b0, 8'h00, 1'b0);
    settle(); chk_idle("t5_end");

`ifdef UART_TX_ARB_HDR_EN
    // Test 6: header 0x82 held under stall, then 0x5A
    set_req(2, 1'b1, 8'h5A, 1'b1);
    tx_ready = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t6_hdr_valid", 32'(tx_valid),  32'd1);
      chk("t6_hdr_data",  32'(tx_data),   32'h82);
      chk("t6_hdr_ready", 32'(req_ready), 32'd0);
      tick();
    end
    tx_ready = 1'b1;
    settle(); chk("t6_hdr_go", 32'(tx_data), 32'h82);
    tick();
    settle(); chk_byte("t6_5a", 2, 8'h5A);
    tick(); set_req(2, 1'b0, 8'h00, 1'b0);
    settle(); chk_idle("t6_end");
`endif

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule
